// File: rtl/sm4_keyexp.sv
// SM4 key expansion: turns a 128-bit master key into 32 round keys,
// one round per clock, packed in encrypt or decrypt word order.
module sm4_keyexp (
    input  logic            CLK_i,
    input  logic            RST_i,
    input  logic [127:0]    KEY_i,
    input  logic            KEY_VALID_i,
    input  logic            DEC_i,
    output logic [1023:0]   RK_o,
    output logic            RK_VALID_o,
    output logic            BUSY_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [127:0] FK = {
        32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
    };

    localparam logic [0:255][7:0] SBOX = {
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7,
        8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3,
        8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a,
        8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95,
        8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba,
        8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b,
        8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2,
        8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52,
        8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5,
        8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55,
        8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60,
        8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f,
        8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f,
        8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd,
        8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e,
        8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20,
        8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    state_t         state;
    state_t         state_nxt;
    logic [31:0]    k0;
    logic [31:0]    k1;
    logic [31:0]    k2;
    logic [31:0]    k3;
    logic [4:0]     cnt;
    logic           dec;
    logic [1023:0]  rk;
    logic           accept;
    logic [7:0]     ck_b0;
    logic [31:0]    ck;
    logic [31:0]    mix;
    logic [31:0]    tau;
    logic [31:0]    rk_new;
    logic [4:0]     widx;

    // Key load is only honoured when no expansion is running
    always_comb begin
        accept = KEY_VALID_i && (state != RUN);
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt  = state;
        BUSY_o     = 1'b0;
        RK_VALID_o = 1'b0;
        unique case (state)
            IDLE: begin
                if (KEY_VALID_i) state_nxt = RUN;
            end
            RUN: begin
                BUSY_o = 1'b1;
                if (cnt == 5'd31) state_nxt = DONE;
            end
            DONE: begin
                RK_VALID_o = 1'b1;
                if (KEY_VALID_i) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // One round: CK bytes step by 7, then tau and the key-schedule L'
    always_comb begin
        ck_b0  = {cnt, 2'b00} * 8'd7;
        ck     = {ck_b0, ck_b0 + 8'd7,
                  ck_b0 + 8'd14, ck_b0 + 8'd21};
        mix    = k1 ^ k2 ^ k3 ^ ck;
        tau    = {SBOX[mix[31:24]], SBOX[mix[23:16]],
                  SBOX[mix[15:8]],  SBOX[mix[7:0]]};
        rk_new = k0 ^ tau
               ^ {tau[18:0], tau[31:19]}
               ^ {tau[8:0],  tau[31:9]};
        widx   = dec ? cnt : ~cnt;
    end

    // Key window, round counter, latched order and packed output
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            k0  <= '0;
            k1  <= '0;
            k2  <= '0;
            k3  <= '0;
            cnt <= '0;
            dec <= 1'b0;
            rk  <= '0;
        end else if (accept) begin
            {k0, k1, k2, k3} <= KEY_i ^ FK;
            cnt <= '0;
            dec <= DEC_i;
        end else if (state == RUN) begin
            rk[{widx, 5'd0} +: 32] <= rk_new;
            k0  <= k1;
            k1  <= k2;
            k2  <= k3;
            k3  <= rk_new;
            cnt <= cnt + 5'd1;
        end
    end

    assign RK_o = rk;

endmodule

// File: tb/tb_sm4_keyexp.sv
// Bench for sm4_keyexp: a word-level key-schedule and cipher model
// checked every cycle, plus directed literal vectors.
module tb_sm4_keyexp;

    logic           CLK_i = 1'b0;
    logic           RST_i;
    logic [127:0]   KEY_i = '0;
    logic           KEY_VALID_i = 1'b0;
    logic           DEC_i = 1'b0;
    logic [1023:0]  RK_o;
    logic           RK_VALID_o;
    logic           BUSY_o;

    int checks = 0;
    int failures = 0;

    localparam logic [127:0] MK = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] CT = 128'h681EDF34D206965E86B3E94F536E4246;
    localparam logic [0:3][31:0] FKW = {
        32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
    };
    localparam logic [0:255][7:0] SB = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    sm4_keyexp dut (
        .CLK_i       (CLK_i),
        .RST_i       (RST_i),
        .KEY_i       (KEY_i),
        .KEY_VALID_i (KEY_VALID_i),
        .DEC_i       (DEC_i),
        .RK_o        (RK_o),
        .RK_VALID_o  (RK_VALID_o),
        .BUSY_o      (BUSY_o)
    );

    always #5 CLK_i = ~CLK_i;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        logic [31:0] y;
        for (int b = 0; b < 4; b++) y[31-8*b -: 8] = SB[x[31-8*b -: 8]];
        return y;
    endfunction

    function automatic logic [0:31][31:0] keysched(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] ck;
        logic [31:0] b;
        logic [0:31][31:0] r;
        for (int j = 0; j < 4; j++) k[j] = mk[127-32*j -: 32] ^ FKW[j];
        for (int i = 0; i < 32; i++) begin
            ck = 0;
            for (int j = 0; j < 4; j++)
                ck = (ck << 8) | 32'(((4 * i + j) * 7) % 256);
            b = subw(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
            r[i] = k[i+4];
        end
        return r;
    endfunction

    function automatic logic [1023:0] pack(input logic [0:31][31:0] r,
                                           input logic d);
        logic [1023:0] v;
        for (int i = 0; i < 32; i++)
            if (!d) v[1023-32*i -: 32] = r[i];
            else    v[32*i+31 -: 32]   = r[i];
        return v;
    endfunction

    // Block cipher using the round keys in MSB-first word order of rkv
    function automatic logic [127:0] cipher(input logic [127:0] blk,
                                            input logic [1023:0] rkv);
        logic [31:0] x [36];
        logic [31:0] b;
        for (int j = 0; j < 4; j++) x[j] = blk[127-32*j -: 32];
        for (int i = 0; i < 32; i++) begin
            b = subw(x[i+1] ^ x[i+2] ^ x[i+3] ^ rkv[1023-32*i -: 32]);
            x[i+4] = x[i] ^ b ^ rotl(b, 2) ^ rotl(b, 10)
                   ^ rotl(b, 18) ^ rotl(b, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s act=%h want=%h", name, act, want);
        end
    endtask

    // Behavioural model: cycles left in the expansion and expected result
    int             m_left = 0;
    logic           m_valid = 1'b0;
    logic [127:0]   m_key = '0;
    logic           m_dec = 1'b0;
    logic [1023:0]  m_rk = '0;

    always @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            m_left  = 0;
            m_valid = 1'b0;
            m_rk    = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1;
                m_rk    = pack(keysched(m_key), m_dec);
            end
        end else if (KEY_VALID_i) begin
            m_left  = 32;
            m_valid = 1'b0;
            m_key   = KEY_i;
            m_dec   = DEC_i;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK_i) begin
        if (RST_i !== 1'bx) begin
            check("busy", 128'(BUSY_o), 128'(m_left > 0));
            check("rk_valid", 128'(RK_VALID_o), 128'(m_valid));
            if (m_valid || RST_i) begin
                checks++;
                if (RK_o !== m_rk) begin
                    failures++;
                    for (int w = 0; w < 32; w++)
                        if (RK_o[1023-32*w -: 32] !== m_rk[1023-32*w -: 32]) begin
                            $display("FAIL rk_word%0d act=%h want=%h", w,
                                     RK_o[1023-32*w -: 32],
                                     m_rk[1023-32*w -: 32]);
                            break;
                        end
                end
            end
        end
    end

    task automatic load(input logic [127:0] key, input logic d);
        @(negedge CLK_i);
        #1;
        KEY_i = key;
        DEC_i = d;
        KEY_VALID_i = 1'b1;
        @(negedge CLK_i);
        #1;
        KEY_VALID_i = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!RK_VALID_o && n < budget) begin
            @(negedge CLK_i);
            n++;
        end
        checks++;
        if (!RK_VALID_o) begin
            failures++;
            $display("FAIL timeout act=%0d want=valid", n);
        end
    endtask

    int n;
    int pulses;
    int last;
    logic [0:31][31:0] gold;

    initial begin
        RST_i = 1'b1;
        #1;
        check("reset_busy", 128'(BUSY_o), 128'(0));
        check("reset_valid", 128'(RK_VALID_o), 128'(0));
        check("reset_rk_lo", RK_o[127:0], 128'(0));
        // model pinned by published round keys and cipher vector
        gold = keysched(MK);
        check("model_rk0", 128'(gold[0]), 128'(32'hF12186F9));
        check("model_rk1", 128'(gold[1]), 128'(32'h41662B61));
        check("model_rk31", 128'(gold[31]), 128'(32'h9124A012));
        check("model_ct", cipher(MK, pack(gold, 1'b0)), CT);
        repeat (3) @(negedge CLK_i);
        #1;
        RST_i = 1'b0;

        // encrypt ordering
        load(MK, 1'b0);
        wait_valid(40, n);
        check("enc_latency", 128'(n), 128'(32));
        check("enc_w0", 128'(RK_o[1023:992]), 128'(32'hF12186F9));
        check("enc_w1", 128'(RK_o[991:960]), 128'(32'h41662B61));
        check("enc_w31", 128'(RK_o[31:0]), 128'(32'h9124A012));
        check("enc_cipher", cipher(MK, RK_o), CT);
        repeat (5) @(negedge CLK_i);
        check("done_hold", 128'(RK_VALID_o), 128'(1));

        // decrypt ordering, accepted from DONE
        load(MK, 1'b1);
        wait_valid(40, n);
        check("dec_latency", 128'(n), 128'(32));
        check("dec_w0", 128'(RK_o[1023:992]), 128'(32'h9124A012));
        check("dec_w31", 128'(RK_o[31:0]), 128'(32'hF12186F9));
        check("dec_cipher", cipher(CT, RK_o), MK);

        // load request at round 10 must be ignored
        load(MK, 1'b0);
        repeat (9) @(negedge CLK_i);
        #1;
        KEY_i = '0;
        DEC_i = 1'b1;
        KEY_VALID_i = 1'b1;
        @(negedge CLK_i);
        #1;
        KEY_VALID_i = 1'b0;
        wait_valid(40, n);
        check("ign_latency", 128'(n), 128'(22));
        check("ign_w0", 128'(RK_o[1023:992]), 128'(32'hF12186F9));
        check("ign_w31", 128'(RK_o[31:0]), 128'(32'h9124A012));

        // held request gives a one-cycle pulse every 33 cycles
        @(negedge CLK_i);
        #1;
        KEY_i = MK;
        DEC_i = 1'b0;
        KEY_VALID_i = 1'b1;
        pulses = 0;
        last = 0;
        for (int i = 1; i <= 110; i++) begin
            @(negedge CLK_i);
            if (RK_VALID_o) begin
                if (pulses > 0) check("pulse_gap", 128'(i - last), 128'(33));
                check("pulse_w0", 128'(RK_o[1023:992]), 128'(32'hF12186F9));
                pulses++;
                last = i;
            end
        end
        check("pulse_count", 128'(pulses), 128'(3));
        #1;
        KEY_VALID_i = 1'b0;
        wait_valid(40, n);

        // reset mid-expansion aborts it
        load(128'h00112233445566778899AABBCCDDEEFF, 1'b1);
        repeat (16) @(negedge CLK_i);
        #2;
        RST_i = 1'b1;
        #1;
        check("abort_busy", 128'(BUSY_o), 128'(0));
        check("abort_valid", 128'(RK_VALID_o), 128'(0));
        check("abort_rk_hi", RK_o[1023:896], 128'(0));
        check("abort_rk_lo", RK_o[127:0], 128'(0));
        repeat (3) @(negedge CLK_i);
        #1;
        RST_i = 1'b0;
        repeat (40) @(negedge CLK_i);
        check("idle_valid", 128'(RK_VALID_o), 128'(0));
        load(MK, 1'b0);
        wait_valid(40, n);
        check("post_latency", 128'(n), 128'(32));
        check("post_cipher", cipher(MK, RK_o), CT);

        // another key through the model only
        load(128'hFEDCBA98765432100123456789ABCDEF, 1'b1);
        wait_valid(40, n);
        repeat (3) @(negedge CLK_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
